// File: rtl/cache_way_ctrl.sv
// Tag/valid/dirty store for an N-way set-associative cache with round-robin replacement.
// Lookups return hit and victim information one cycle after they are accepted.
module cache_way_ctrl #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 32,
  parameter int unsigned TAG_WIDTH = 20,
  localparam int unsigned SET_W    = $clog2(SETS),
  localparam int unsigned WAY_W    = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rest,
  output logic                 ready,
  input  logic                 lookupValid,
  input  logic [SET_W-1:0]     lookupSet,
  input  logic [TAG_WIDTH-1:0] lookupTag,
  output logic                 resultValid,
  output logic                 hit,
  output logic [WAY_W-1:0]     hitWay,
  output logic [WAY_W-1:0]     victimWay,
  output logic                 victimDirty,
  output logic [TAG_WIDTH-1:0] victimTag,
  input  logic                 fillEn,
  input  logic [SET_W-1:0]     fillSet,
  input  logic [WAY_W-1:0]     fillWay,
  input  logic [TAG_WIDTH-1:0] fillTag,
  input  logic                 fillDirty,
  input  logic                 dirtyEn,
  input  logic [SET_W-1:0]     dirtySet,
  input  logic [WAY_W-1:0]     dirtyWay,
  input  logic                 flushReq
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state;
  logic [SET_W-1:0] sweepCnt;
  logic             run;

  logic [WAYS-1:0]      validMem [SETS];
  logic [WAYS-1:0]      dirtyMem [SETS];
  logic [WAY_W-1:0]     rrPtr    [SETS];
  logic [TAG_WIDTH-1:0] tagMem   [SETS][WAYS];

  logic                 resValid;
  logic [SET_W-1:0]     lkSet;
  logic [TAG_WIDTH-1:0] lkTag;

  logic lookupGo, fillGo, dirtyGo;

  assign run   = (state == StRun);
  assign ready = run;

  // A flush request wins over every other request presented in the same cycle.
  assign lookupGo = run & lookupValid & ~flushReq;
  assign fillGo   = run & fillEn & ~flushReq;
  assign dirtyGo  = run & dirtyEn & ~flushReq;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state    <= StInit;
      sweepCnt <= '0;
    end else if (!run) begin
      sweepCnt <= sweepCnt + 1'b1;
      if (sweepCnt == SET_W'(SETS - 1)) begin
        state <= StRun;
      end
    end else if (flushReq) begin
      state    <= StInit;
      sweepCnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      resValid <= 1'b0;
      lkSet    <= '0;
      lkTag    <= '0;
    end else begin
      resValid <= lookupGo;
      if (lookupGo) begin
        lkSet <= lookupSet;
        lkTag <= lookupTag;
      end
    end
  end

  // Dirty mark is written after the fill so a same-way collision leaves the line dirty.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int s = 0; s < SETS; s++) begin
        validMem[s] <= '0;
        dirtyMem[s] <= '0;
        rrPtr[s]    <= '0;
      end
    end else if (!run) begin
      validMem[sweepCnt] <= '0;
      dirtyMem[sweepCnt] <= '0;
      rrPtr[sweepCnt]    <= '0;
    end else begin
      if (fillGo) begin
        validMem[fillSet][fillWay] <= 1'b1;
        dirtyMem[fillSet][fillWay] <= fillDirty;
        rrPtr[fillSet]             <= fillWay + WAY_W'(1);
      end
      if (dirtyGo) begin
        dirtyMem[dirtySet][dirtyWay] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fillGo) begin
      tagMem[fillSet][fillWay] <= fillTag;
    end
  end

  logic             hitAny, invAny;
  logic [WAY_W-1:0] hitIdx, invIdx, vicIdx;

  // Descending scan so the lowest matching / lowest invalid way is the one kept.
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    invAny = 1'b0;
    invIdx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (validMem[lkSet][w] && (tagMem[lkSet][w] == lkTag)) begin
        hitAny = 1'b1;
        hitIdx = WAY_W'(w);
      end
      if (!validMem[lkSet][w]) begin
        invAny = 1'b1;
        invIdx = WAY_W'(w);
      end
    end
    vicIdx = invAny ? invIdx : rrPtr[lkSet];
  end

  assign resultValid = resValid;
  assign hit         = resValid & hitAny;
  assign hitWay      = resValid ? hitIdx : '0;
  assign victimWay   = resValid ? vicIdx : '0;
  assign victimDirty = resValid & validMem[lkSet][vicIdx] & dirtyMem[lkSet][vicIdx];
  assign victimTag   = resValid ? tagMem[lkSet][vicIdx] : '0;

endmodule

// File: doc/cache_way_ctrl.md
Name: cache_way_ctrl

Overview:
- Parametrised N-way set-associative tag/state controller for the cache.
- Holds tag, valid and dirty bits per way and a round-robin replacement pointer per set.
- Performs a one-cycle-latency hit/victim lookup and accepts fill and dirty-mark updates.
- Sits beside the data RAM. The cache FSM uses hitWay as the data-RAM way select, and uses victimWay/victimDirty/victimTag for refill and write-back.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 32, number of sets; power of two, >=2.
- TAG_WIDTH, 20, stored tag bits.
- SET_W, log2(SETS), derived; not overridable.
- WAY_W, log2(WAYS), derived; not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rest  in  1  reset, asynchronous, active-low.
- ready  out  1  1 = lookups/updates accepted; 0 during init/flush sweep.
- lookupValid  in  1  lookup request.
- lookupSet  in  SET_W  set index.
- lookupTag  in  TAG_WIDTH  tag compared.
- resultValid  out  1  result strobe, one cycle after accepted lookup.
- hit  out  1  tag matched a valid way.
- hitWay  out  WAY_W  matching way; lowest index if several match.
- victimWay  out  WAY_W  way to replace on miss.
- victimDirty  out  1  victim way is valid and dirty.
- victimTag  out  TAG_WIDTH  stored tag of victim way.
- fillEn  in  1  install line.
- fillSet  in  SET_W  set index for fill.
- fillWay  in  WAY_W  way for fill.
- fillTag  in  TAG_WIDTH  tag for fill.
- fillDirty  in  1  dirty value written with the fill.
- dirtyEn  in  1  mark a way dirty (write hit).
- dirtySet  in  SET_W  set index for dirty mark.
- dirtyWay  in  WAY_W  way for dirty mark.
- flushReq  in  1  invalidate all lines.

Behaviour:
- States: INIT, RUN.
- rest low (any time, including mid-sweep or mid-lookup) → INIT with sweep counter 0. Reset values:
  - ready=0, resultValid=0, hit=0, hitWay=0, victimWay=0, victimDirty=0, victimTag=0.
  - All rr pointers=0.
- INIT: each cycle clear valid, dirty and rr pointer of set[counter]; counter+1. After set SETS-1 is cleared → RUN.
  - ready rises the cycle after the last clear: SETS cycles after rest rises.
  - lookupValid, fillEn, dirtyEn and flushReq are ignored in INIT.
- RUN: ready=1.
  - lookupValid at cycle N: set and tag are registered. At N+1, resultValid=1 and the outputs are computed combinationally against current arrays.
  - A fill or dirty mark performed in cycle N is visible in the N+1 result; one in cycle N+1 is not.
  - resultValid is 0 in any cycle with no lookup accepted in the prior cycle. Back-to-back lookups give one result per cycle.
- Victim selection:
  - Lowest-index invalid way.
  - If all ways are valid: rrPtr[set].
  - victimDirty = valid & dirty of that way.
  - Victim outputs are produced on hit as well; the controller ignores them then.
- Fill (fillEn, RUN): tag[set][way]=fillTag, valid=1, dirty=fillDirty, and rrPtr[set]=(fillWay+1) mod WAYS with natural wrap.
- Dirty mark (dirtyEn, RUN): dirty[set][way]=1 whether valid or not. No effect on rrPtr.
- Fill and dirty mark to the same set/way in the same cycle: dirty=1.
- flushReq in RUN → INIT next cycle; full sweep; ready=0 next cycle.
  - Same-cycle fill, dirty mark and lookup are dropped: no resultValid.
  - A result for a lookup accepted in the cycle before flushReq is still produced.
- Hits do not change replacement state.

Test Plan:
- Reset, SETS=32 → ready=0 for 32 cycles after rest rises, then 1. Lookup set 5 tag 0x12345 → resultValid one cycle later, hit=0, victimWay=0, victimDirty=0.
- Fill set 5 way 0 tag 0x12345 fillDirty=0, then lookup same → hit=1, hitWay=0. Lookup tag 0x12346 → hit=0, victimWay=1.
- Fill ways 0..3 of set 7 in order, lookup miss → victimWay=0 (rr wrapped from 3). Fill way 0 again → next miss victimWay=1.
- Fill set 2 way 1 tag 0xABCDE, dirtyEn set 2 way 1, fill ways 0/2/3, then fill way 0 so rrPtr=1 → miss: victimWay=1, victimDirty=1, victimTag=0xABCDE.
- Fill in cycle N and lookup of that tag in cycle N → hit=1. Fill in N+1 after a lookup in N → hit=0.
- flushReq with lookupValid asserted → no resultValid, ready=0 for 32 cycles, then previously filled tags miss. Pulse rest low mid-sweep → sweep restarts and ready stays 0 a full 32 cycles after rest rises.
